hex_scan_driver: RTL and testbench

HEX_SCAN_DRIVER -- requirements
Module: hex_scan_driver

---
 rtl/hex_scan_driver.sv | 168 ++++++++++++++++
 tb/tb_hex_scan_driver.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/hex_scan_driver.sv
// hex_scan_driver: time-multiplexed driver for an eight-digit, common-anode
// seven-segment display. A prescaler divides sys_clk_in down to the per-digit
// scan rate. The first blank_cycles clocks of every digit slot are dark so
// the previous digit's segments never ghost onto the next anode. Inputs are
// captured into shadow registers once per frame so a frame never tears.
module hex_scan_driver #(
    parameter logic [27:0] clk_freq     = 28'd100_000000,
    parameter int          scan_freqHz  = 1000,
    parameter int          blank_cycles = 16
) (
    input  logic        sys_clk_in,
    input  logic        reset,
    input  logic [63:0] binary_in,
    input  logic [7:0]  dp,
    input  logic [7:0]  digit_en,
    output logic [7:0]  display_out,
    output logic [7:0]  seg_control,
    output logic        frame_start
);

    // Clocks per digit slot; callers guarantee slot_len >= blank_cycles + 2.
    localparam int slot_len = int'(clk_freq) / scan_freqHz;
    localparam int cw       = (slot_len > 1) ? $clog2(slot_len) : 1;

    localparam logic [cw-1:0] last_count = cw'(slot_len - 1);
    localparam logic [cw-1:0] blank_end  = cw'(blank_cycles);

    // Prescaler and digit scan state.
    logic [cw-1:0] count;
    logic [2:0]    index;
    logic          tick;
    logic          frame_load;

    // Set by reset so the first clock after release captures fresh inputs.
    logic          load_pending;
    logic          shadow_load;

    // Per-frame snapshot of the display inputs. Only the low eight nibbles
    // name digits; the upper half of binary_in has no digit to drive.
    logic [31:0]   shadow_bin;
    logic [7:0]    shadow_dp;
    logic [7:0]    shadow_en;

    // Values actually used for the slot being decoded this clock.
    logic [31:0]   cur_bin;
    logic [7:0]    cur_dp;
    logic [7:0]    cur_en;

    logic          in_blank;
    logic [3:0]    nibble;
    logic [6:0]    seg7;
    logic [7:0]    next_seg;
    logic [7:0]    next_disp;

    logic          unused_bits;
    assign unused_bits = ^binary_in[63:32];

    assign tick        = (count == last_count);
    assign frame_load  = tick && (index == 3'd7);
    assign shadow_load = load_pending || frame_load;
    assign in_blank    = (count < blank_end);

    // On the post-reset load clock the shadows still hold zero, so decode
    // straight from the inputs that are being captured on that same edge.
    assign cur_bin = load_pending ? binary_in[31:0] : shadow_bin;
    assign cur_dp  = load_pending ? dp              : shadow_dp;
    assign cur_en  = load_pending ? digit_en        : shadow_en;

    // Prescaler: counts 0..slot_len-1 and wraps, tick marks the last count.
    always_ff @(posedge sys_clk_in or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // Digit index advances once per slot and wraps 7 -> 0 by overflow.
    always_ff @(posedge sys_clk_in or negedge reset) begin
        if (!reset) begin
            index <= 3'd0;
        end else if (tick) begin
            index <= index + 3'd1;
        end
    end

    // Remembers that the next clock is the first one after reset release.
    always_ff @(posedge sys_clk_in or negedge reset) begin
        if (!reset) begin
            load_pending <= 1'b1;
        end else begin
            load_pending <= 1'b0;
        end
    end

    // Shadow capture: after reset and at the end of every frame only.
    always_ff @(posedge sys_clk_in or negedge reset) begin
        if (!reset) begin
            shadow_bin <= '0;
            shadow_dp  <= '0;
            shadow_en  <= '0;
        end else if (shadow_load) begin
            shadow_bin <= binary_in[31:0];
            shadow_dp  <= dp;
            shadow_en  <= digit_en;
        end
    end

    // Hex to active-low {g,f,e,d,c,b,a} decode of the current digit nibble.
    always_comb begin
        seg7   = 7'h7F;
        nibble = cur_bin[{index, 2'b00} +: 4];
        case (nibble)
            4'h0:    seg7 = 7'h40;
            4'h1:    seg7 = 7'h79;
            4'h2:    seg7 = 7'h24;
            4'h3:    seg7 = 7'h30;
            4'h4:    seg7 = 7'h19;
            4'h5:    seg7 = 7'h12;
            4'h6:    seg7 = 7'h02;
            4'h7:    seg7 = 7'h78;
            4'h8:    seg7 = 7'h00;
            4'h9:    seg7 = 7'h10;
            4'hA:    seg7 = 7'h08;
            4'hB:    seg7 = 7'h03;
            4'hC:    seg7 = 7'h46;
            4'hD:    seg7 = 7'h21;
            4'hE:    seg7 = 7'h06;
            4'hF:    seg7 = 7'h0E;
            default: seg7 = 7'h7F;
        endcase
    end

    // Output selection: dark while blanking or for a disabled digit,
    // otherwise a single low anode bit and the decoded segments plus dp.
    always_comb begin
        next_seg  = 8'hFF;
        next_disp = 8'hFF;
        if (!in_blank && cur_en[index]) begin
            next_seg  = ~(8'b0000_0001 << index);
            next_disp = {cur_dp[index], seg7};
        end
    end

    // Registered outputs, one clock behind the prescaler/index state.
    always_ff @(posedge sys_clk_in or negedge reset) begin
        if (!reset) begin
            seg_control <= 8'hFF;
            display_out <= 8'hFF;
        end else begin
            seg_control <= next_seg;
            display_out <= next_disp;
        end
    end

    // Frame pulse: high for the one clock in which the index has just
    // wrapped from 7 back to 0.
    always_ff @(posedge sys_clk_in or negedge reset) begin
        if (!reset) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_load;
        end
    end

endmodule

// File: tb/tb_hex_scan_driver.sv
// Bench for hex_scan_driver with a 10-clock slot (100 Hz / 10 Hz) and two
// blank cycles, giving an 80-clock frame.
module tb_hex_scan_driver;

    logic        clk;
    logic        reset;
    logic [63:0] binary_in;
    logic [7:0]  dp;
    logic [7:0]  digit_en;
    logic [7:0]  display_out;
    logic [7:0]  seg_control;
    logic        frame_start;

    int checks;
    int errors;

    typedef struct {
        logic [63:0] bin;
        logic [7:0]  dp;
        logic [7:0]  en;
        logic [63:0] exp_disp;  // byte d = expected display_out when digit d is lit
    } vec_t;

    vec_t vecs[5];

    hex_scan_driver #(
        .clk_freq     (28'd100),
        .scan_freqHz  (10),
        .blank_cycles (2)
    ) dut (
        .sys_clk_in  (clk),
        .reset       (reset),
        .binary_in   (binary_in),
        .dp          (dp),
        .digit_en    (digit_en),
        .display_out (display_out),
        .seg_control (seg_control),
        .frame_start (frame_start)
    );

    // Clock and reset defaults.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-hot anode check across the whole run.
    always @(negedge clk) begin
        checks++;
        assert ($countones(~seg_control) <= 1)
        else begin
            errors++;
            $display("FAIL onehot: seg_control got %h want at most one zero bit", seg_control);
        end
    end

    task automatic check8(input string name, input int d, input int c,
                          input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s digit %0d cycle %0d: got %h want %h", name, d, c, got, want);
        end
    endtask

    task automatic apply(input int v);
        binary_in = vecs[v].bin;
        dp        = vecs[v].dp;
        digit_en  = vecs[v].en;
    endtask

    // Walks one whole frame from slot 0, checking every clock. When
    // apply_next is set, the next vector is driven once index is 3.
    task automatic check_frame(input int v, input bit apply_next);
        logic [7:0] exp_seg;
        logic [7:0] exp_disp;
        logic [7:0] exp_fs;
        for (int d = 0; d < 8; d++) begin
            for (int c = 0; c < 10; c++) begin
                @(posedge clk);
                @(negedge clk);
                if (apply_next && d == 3 && c == 0) apply(v + 1);
                if (c < 2 || !vecs[v].en[d]) begin
                    exp_seg  = 8'hFF;
                    exp_disp = 8'hFF;
                end else begin
                    exp_seg  = ~(8'b0000_0001 << d);
                    exp_disp = vecs[v].exp_disp[8*d +: 8];
                end
                exp_fs = (d == 7 && c == 9) ? 8'h01 : 8'h00;
                check8($sformatf("v%0d seg_control", v), d, c, seg_control, exp_seg);
                check8($sformatf("v%0d display_out", v), d, c, display_out, exp_disp);
                check8($sformatf("v%0d frame_start", v), d, c, {7'b0, frame_start}, exp_fs);
            end
        end
    endtask

    // Counts clocks until the next frame_start pulse, bounded.
    task automatic measure_period(output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
        end while (!frame_start && cnt < 200);
    endtask

    initial begin
        int period;

        checks = 0;
        errors = 0;

        //                bin                     dp     en     exp_disp (d7..d0)
        vecs[0] = '{64'h0123456789ABCDEF, 8'hFF, 8'hFF, 64'h80908883C6A1868E};
        vecs[1] = '{64'h0000000000000000, 8'hFF, 8'hFF, 64'hC0C0C0C0C0C0C0C0};
        vecs[2] = '{64'h0000000076543210, 8'hFE, 8'h0F, 64'hFFFFFFFFB0A4F940};
        vecs[3] = '{64'h00000000FEDCBA98, 8'h55, 8'hAA, 64'h0EFF21FF03FF10FF};
        vecs[4] = '{64'hDEADBEEF76547654, 8'h0F, 8'hFF, 64'h78021219F8829299};

        // Power-on reset with the first vector already driven.
        reset = 1'b0;
        apply(0);
        repeat (3) @(negedge clk);
        check8("reset seg_control", 0, 0, seg_control, 8'hFF);
        check8("reset display_out", 0, 0, display_out, 8'hFF);
        check8("reset frame_start", 0, 0, {7'b0, frame_start}, 8'h00);
        reset = 1'b1;

        // Table: each frame shows the vector captured before it; the next
        // vector arrives mid-frame and must not tear the current one.
        for (int v = 0; v < 5; v++) begin
            check_frame(v, v < 4);
        end

        // Frame period between consecutive pulses.
        measure_period(period);
        check8("frame period 1", 0, 0, 8'(period), 8'd80);
        measure_period(period);
        check8("frame period 2", 0, 0, 8'(period), 8'd80);

        // Reset mid-slot: digit 0 is lit, then reset drops between edges.
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        check8("pre-reset seg_control", 0, 4, seg_control, 8'hFE);
        check8("pre-reset display_out", 0, 4, display_out, 8'h99);
        #2 reset = 1'b0;
        #1;
        check8("async reset seg_control", 0, 4, seg_control, 8'hFF);
        check8("async reset display_out", 0, 4, display_out, 8'hFF);
        check8("async reset frame_start", 0, 4, {7'b0, frame_start}, 8'h00);
        repeat (2) @(negedge clk);
        check8("held reset seg_control", 0, 0, seg_control, 8'hFF);
        check8("held reset display_out", 0, 0, display_out, 8'hFF);

        // Release with new inputs: restart at digit 0 with a fresh load.
        apply(0);
        reset = 1'b1;
        check_frame(0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
